// File: rtl/l2_req_arbiter_rr.sv
// Arbitrates N L1-side requesters onto the single L2 request port, holding the
// grant until L2 fulfils and steering the response back to the granted port only.
package l2_req_arbiter_rr_pkg;
    typedef enum logic {
        LOAD  = 1'b0,
        STORE = 1'b1
    } memory_operation_e;
endpackage

module l2_req_arbiter_rr
    import l2_req_arbiter_rr_pkg::*;
#(
    parameter int unsigned        XLEN    = 32,
    parameter int unsigned        NUM_REQ = 4,
    parameter bit                 RR_MODE = 1'b1,
    parameter logic [NUM_REQ-1:0] RO_MASK = NUM_REQ'(1),
    localparam int unsigned       IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_REQ*XLEN-1:0]              up_req_address,
    input  memory_operation_e [NUM_REQ-1:0]      up_req_type,
    input  logic [NUM_REQ-1:0]                   up_req_valid,
    input  logic [NUM_REQ*XLEN-1:0]              up_word_to_store,
    output logic [NUM_REQ*XLEN-1:0]              up_fetched_word,
    output logic [NUM_REQ-1:0]                   up_req_fulfilled,
    output logic [XLEN-1:0]                      req_address,
    output memory_operation_e                    req_type,
    output logic                                 req_valid,
    output logic [XLEN-1:0]                      word_to_store,
    input  logic [XLEN-1:0]                      fetched_word,
    input  logic                                 req_fulfilled,
    output logic [NUM_REQ-1:0]                   grant_onehot,
    output logic                                 busy,
    output logic                                 dbg_state,
    output logic [IDX_W-1:0]                     dbg_rr_ptr
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // Handshake: a requester holds up_req_valid (and its payload) until it sees
    // its up_req_fulfilled pulse; L2 completes a request with one req_fulfilled
    // pulse, which may coincide with the first cycle req_valid is high.

    state_e           state_q, state_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [IDX_W-1:0] winner;
    logic             any_valid;
    logic [IDX_W:0]   scan_idx;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_active;
    logic             done;

    // Scan starts at rr_ptr in round-robin mode and at port 0 in fixed mode.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        scan_idx  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_idx = RR_MODE ? ({1'b0, rr_ptr_q} + (IDX_W+1)'(k)) : (IDX_W+1)'(k);
            if (scan_idx >= (IDX_W+1)'(NUM_REQ)) begin
                scan_idx = scan_idx - (IDX_W+1)'(NUM_REQ);
            end
            if (!any_valid && up_req_valid[scan_idx[IDX_W-1:0]]) begin
                any_valid = 1'b1;
                winner    = scan_idx[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        sel_idx    = (state_q == BUSY) ? grant_idx_q : winner;
        sel_active = !reset && ((state_q == BUSY) || any_valid);
    end

    always_comb begin
        req_valid        = 1'b0;
        req_address      = '0;
        req_type         = LOAD;
        word_to_store    = '0;
        grant_onehot     = '0;
        up_fetched_word  = '0;
        up_req_fulfilled = '0;
        if (sel_active) begin
            grant_onehot[sel_idx] = 1'b1;
            req_valid             = up_req_valid[sel_idx];
            req_address           = up_req_address[sel_idx*XLEN +: XLEN];
            if (!RO_MASK[sel_idx]) begin
                req_type      = up_req_type[sel_idx];
                word_to_store = up_word_to_store[sel_idx*XLEN +: XLEN];
            end
            up_req_fulfilled[sel_idx]            = req_fulfilled;
            up_fetched_word[sel_idx*XLEN +: XLEN] = fetched_word;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        rr_ptr_d    = rr_ptr_q;
        done        = 1'b0;
        if (state_q == IDLE) begin
            if (any_valid) begin
                grant_idx_d = winner;
                if (req_fulfilled) begin
                    done = 1'b1;
                end else begin
                    state_d = BUSY;
                end
            end
        end else if (req_fulfilled) begin
            state_d = IDLE;
            done    = 1'b1;
        end else if (!up_req_valid[grant_idx_q]) begin
            // Requester abandoned its request: release the lock, keep rr_ptr.
            state_d = IDLE;
        end
        if (done && RR_MODE) begin
            rr_ptr_d = (sel_idx == IDX_W'(NUM_REQ-1)) ? '0 : sel_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_idx_q <= '0;
            rr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign busy       = !reset && (state_q == BUSY);
    assign dbg_state  = (state_q == BUSY);
    assign dbg_rr_ptr = rr_ptr_q;

endmodule

// File: tb/tb_l2_req_arbiter_rr.sv
// Bench for l2_req_arbiter_rr: one fixed-priority and one round-robin instance,
// directed stimulus, and a per-cycle behavioural model of grant/response rules.
module tb_l2_req_arbiter_rr;
    import l2_req_arbiter_rr_pkg::*;

    localparam int XLEN = 32;
    localparam int N    = 4;
    localparam logic [N-1:0] RO = 4'b0001;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // index 0 = fixed-priority instance, index 1 = round-robin instance
    logic [N*XLEN-1:0]        up_addr  [2];
    memory_operation_e [N-1:0] up_type [2];
    logic [N-1:0]             up_valid [2];
    logic [N*XLEN-1:0]        up_data  [2];
    logic [N*XLEN-1:0]        up_fw    [2];
    logic [N-1:0]             up_ful   [2];
    logic [XLEN-1:0]          rq_addr  [2];
    memory_operation_e        rq_type  [2];
    logic                     rq_valid [2];
    logic [XLEN-1:0]          rq_data  [2];
    logic [XLEN-1:0]          l2_fw    [2];
    logic                     l2_ful   [2];
    logic [N-1:0]             gnt      [2];
    logic                     bsy      [2];
    logic                     dstate   [2];
    logic [1:0]               dptr     [2];

    l2_req_arbiter_rr #(.XLEN(XLEN), .NUM_REQ(N), .RR_MODE(1'b0), .RO_MASK(RO)) u_fixed (
        .clk(clk), .reset(reset),
        .up_req_address(up_addr[0]), .up_req_type(up_type[0]), .up_req_valid(up_valid[0]),
        .up_word_to_store(up_data[0]), .up_fetched_word(up_fw[0]), .up_req_fulfilled(up_ful[0]),
        .req_address(rq_addr[0]), .req_type(rq_type[0]), .req_valid(rq_valid[0]),
        .word_to_store(rq_data[0]), .fetched_word(l2_fw[0]), .req_fulfilled(l2_ful[0]),
        .grant_onehot(gnt[0]), .busy(bsy[0]), .dbg_state(dstate[0]), .dbg_rr_ptr(dptr[0])
    );

    l2_req_arbiter_rr #(.XLEN(XLEN), .NUM_REQ(N), .RR_MODE(1'b1), .RO_MASK(RO)) u_rr (
        .clk(clk), .reset(reset),
        .up_req_address(up_addr[1]), .up_req_type(up_type[1]), .up_req_valid(up_valid[1]),
        .up_word_to_store(up_data[1]), .up_fetched_word(up_fw[1]), .up_req_fulfilled(up_ful[1]),
        .req_address(rq_addr[1]), .req_type(rq_type[1]), .req_valid(rq_valid[1]),
        .word_to_store(rq_data[1]), .fetched_word(l2_fw[1]), .req_fulfilled(l2_ful[1]),
        .grant_onehot(gnt[1]), .busy(bsy[1]), .dbg_state(dstate[1]), .dbg_rr_ptr(dptr[1])
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int d, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at %0t", name, d, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         lock [2];     // locked port, -1 when idle
    int         ptr  [2];     // round-robin start point
    logic [N-1:0] ro_mask;
    logic       is_rr [2];

    function automatic int pick(input int d);
        int start;
        int p;
        start = is_rr[d] ? ptr[d] : 0;
        for (int k = 0; k < N; k++) begin
            p = (start + k) % N;
            if (up_valid[d][p]) return p;
        end
        return -1;
    endfunction

    task automatic model_cycle(input int d);
        int                port;
        logic [N-1:0]      v;
        logic              rf;
        logic [N-1:0]      e_gnt;
        logic              e_valid;
        logic [XLEN-1:0]   e_addr;
        logic [XLEN-1:0]   e_data;
        memory_operation_e e_type;
        logic [127:0]      e_fw;
        v  = up_valid[d];
        rf = l2_ful[d];
        if (reset) begin
            chk("rst_req_valid", d, rq_valid[d], 0);
            chk("rst_grant", d, gnt[d], 0);
            chk("rst_busy", d, bsy[d], 0);
            chk("rst_up_fulfilled", d, up_ful[d], 0);
            lock[d] = -1;
            ptr[d]  = 0;
        end else begin
            port    = (lock[d] >= 0) ? lock[d] : pick(d);
            e_gnt   = '0;
            e_valid = 1'b0;
            e_addr  = '0;
            e_data  = '0;
            e_type  = LOAD;
            e_fw    = '0;
            if (port >= 0) begin
                e_gnt[port] = 1'b1;
                e_valid     = v[port];
                e_addr      = up_addr[d][port*XLEN +: XLEN];
                if (!ro_mask[port]) begin
                    e_type = up_type[d][port];
                    e_data = up_data[d][port*XLEN +: XLEN];
                end
                e_fw = 128'(l2_fw[d]) << (port * XLEN);
            end
            chk("m_grant", d, gnt[d], e_gnt);
            chk("m_req_valid", d, rq_valid[d], e_valid);
            chk("m_req_address", d, rq_addr[d], e_addr);
            chk("m_req_type", d, 128'(rq_type[d]), 128'(e_type));
            chk("m_word_to_store", d, rq_data[d], e_data);
            chk("m_up_fulfilled", d, up_ful[d], rf ? e_gnt : '0);
            chk("m_up_fetched", d, up_fw[d], e_fw);
            chk("m_busy", d, bsy[d], lock[d] >= 0);
            chk("m_state", d, dstate[d], lock[d] >= 0);
            chk("m_rr_ptr", d, dptr[d], ptr[d]);
            if (lock[d] >= 0) begin
                if (rf) begin
                    lock[d] = -1;
                    if (is_rr[d]) ptr[d] = (port + 1) % N;
                end else if (!v[port]) begin
                    lock[d] = -1;
                end
            end else if (port >= 0) begin
                if (rf) begin
                    if (is_rr[d]) ptr[d] = (port + 1) % N;
                end else begin
                    lock[d] = port;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) model_cycle(d);
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic set_req(input int d, input int p, input logic v, input logic [XLEN-1:0] a,
                           input memory_operation_e t, input logic [XLEN-1:0] w);
        up_valid[d][p]            = v;
        up_addr[d][p*XLEN +: XLEN] = a;
        up_type[d][p]             = t;
        up_data[d][p*XLEN +: XLEN] = w;
    endtask

    task automatic l2(input int d, input logic rf, input logic [XLEN-1:0] fw);
        l2_ful[d] = rf;
        l2_fw[d]  = fw;
    endtask

    task automatic clear(input int d);
        for (int p = 0; p < N; p++) set_req(d, p, 1'b0, '0, LOAD, '0);
        l2(d, 1'b0, '0);
    endtask

    logic [3:0] t2_g [4];
    logic [1:0] t2_p [4];

    initial begin
        ro_mask  = RO;
        is_rr[0] = 1'b0;
        is_rr[1] = 1'b1;
        t2_g = '{4'b0001, 4'b0010, 4'b0100, 4'b0001};
        t2_p = '{2'd1, 2'd2, 2'd3, 2'd1};
        for (int d = 0; d < 2; d++) begin
            lock[d] = -1;
            ptr[d]  = 0;
            clear(d);
        end
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        at_neg();
        chk("post_rst_busy", 0, bsy[0], 0);
        chk("post_rst_rr_ptr", 1, dptr[1], 0);

        // fixed priority: ports 1 and 3 together, fulfil after 3 cycles
        tick();
        set_req(0, 1, 1'b1, 32'h100, LOAD, '0);
        set_req(0, 3, 1'b1, 32'h300, LOAD, '0);
        at_neg();
        chk("t1_grant_p1", 0, gnt[0], 4'b0010);
        chk("t1_addr_p1", 0, rq_addr[0], 32'h100);
        tick();
        tick();
        tick();
        l2(0, 1'b1, 32'hDEAD_BEEF);
        at_neg();
        chk("t1_p1_word", 0, up_fw[0][63:32], 32'hDEAD_BEEF);
        chk("t1_only_p1_fulfilled", 0, up_ful[0], 4'b0010);
        tick();
        l2(0, 1'b0, '0);
        set_req(0, 1, 1'b0, '0, LOAD, '0);
        at_neg();
        chk("t1_grant_p3", 0, gnt[0], 4'b1000);
        chk("t1_addr_p3", 0, rq_addr[0], 32'h300);
        chk("t1_req_valid_p3", 0, rq_valid[0], 1);
        tick();
        l2(0, 1'b1, 32'h3333_3333);
        at_neg();
        chk("t1_p3_fulfilled", 0, up_ful[0], 4'b1000);
        tick();
        clear(0);

        // round robin: ports 0,1,2 held valid, fulfil after 2 cycles
        set_req(1, 0, 1'b1, 32'h10, LOAD, '0);
        set_req(1, 1, 1'b1, 32'h11, LOAD, '0);
        set_req(1, 2, 1'b1, 32'h12, LOAD, '0);
        for (int k = 0; k < 4; k++) begin
            at_neg();
            chk("t2_grant", 1, gnt[1], t2_g[k]);
            if (k > 0) chk("t2_rr_ptr", 1, dptr[1], t2_p[k-1]);
            tick();
            tick();
            l2(1, 1'b1, 32'hA0 + k);
            at_neg();
            chk("t2_fulfilled", 1, up_ful[1], t2_g[k]);
            tick();
            l2(1, 1'b0, '0);
        end
        at_neg();
        chk("t2_rr_ptr_last", 1, dptr[1], t2_p[3]);

        // port 1 was granted again, then drops valid while locked
        tick();
        clear(1);
        at_neg();
        chk("t_abort_busy", 1, bsy[1], 1);
        chk("t_abort_req_valid", 1, rq_valid[1], 0);
        tick();
        l2(1, 1'b1, 32'h55);
        at_neg();
        chk("t_abort_idle", 1, bsy[1], 0);
        chk("t_abort_no_fulfil", 1, up_ful[1], 0);
        tick();
        l2(1, 1'b0, '0);
        at_neg();
        chk("t_abort_ptr_kept", 1, dptr[1], 1);

        // zero-wait L2 on port 2, which also moves rr_ptr to 3
        tick();
        set_req(1, 2, 1'b1, 32'h22, LOAD, '0);
        l2(1, 1'b1, 32'hCAFE_F00D);
        at_neg();
        chk("t3_zw_busy", 1, bsy[1], 0);
        chk("t3_zw_fulfilled", 1, up_ful[1], 4'b0100);
        chk("t3_zw_word", 1, up_fw[1][95:64], 32'hCAFE_F00D);
        tick();
        clear(1);
        at_neg();
        chk("t3_zw_stays_idle", 1, bsy[1], 0);
        chk("t3_ptr3", 1, dptr[1], 2'd3);

        // wrap: ptr 3 with ports 0 and 3 valid
        tick();
        set_req(1, 0, 1'b1, 32'h30, LOAD, '0);
        set_req(1, 3, 1'b1, 32'h33, LOAD, '0);
        at_neg();
        chk("t3_wrap_grant_p3", 1, gnt[1], 4'b1000);
        tick();
        l2(1, 1'b1, 32'h77);
        at_neg();
        chk("t3_wrap_ful_p3", 1, up_ful[1], 4'b1000);
        tick();
        l2(1, 1'b0, '0);
        set_req(1, 3, 1'b0, '0, LOAD, '0);
        at_neg();
        chk("t3_wrap_ptr0", 1, dptr[1], 2'd0);
        chk("t3_wrap_grant_p0", 1, gnt[1], 4'b0001);
        tick();
        l2(1, 1'b1, 32'h78);
        tick();
        clear(1);

        // read-only port 0 store is demoted; writable port 1 store passes
        tick();
        set_req(1, 0, 1'b1, 32'h40, STORE, 32'h1234);
        l2(1, 1'b1, '0);
        at_neg();
        chk("t4_ro_type", 1, 128'(rq_type[1]), 128'(LOAD));
        chk("t4_ro_data", 1, rq_data[1], 0);
        chk("t4_ro_valid", 1, rq_valid[1], 1);
        tick();
        set_req(1, 0, 1'b0, '0, LOAD, '0);
        set_req(1, 1, 1'b1, 32'h44, STORE, 32'h1234);
        at_neg();
        chk("t4_rw_grant", 1, gnt[1], 4'b0010);
        chk("t4_rw_type", 1, 128'(rq_type[1]), 128'(STORE));
        chk("t4_rw_data", 1, rq_data[1], 32'h1234);
        tick();
        clear(1);

        // reset while port 2 is locked on both instances, L2 fulfilling during reset
        tick();
        set_req(0, 2, 1'b1, 32'h200, LOAD, '0);
        set_req(1, 2, 1'b1, 32'h210, LOAD, '0);
        tick();
        at_neg();
        for (int d = 0; d < 2; d++) begin
            chk("t5_busy_before", d, bsy[d], 1);
            chk("t5_grant_p2", d, gnt[d], 4'b0100);
        end
        tick();
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            l2(d, 1'b1, 32'h9999);
            set_req(d, 0, 1'b1, 32'h80, LOAD, '0);
        end
        at_neg();
        for (int d = 0; d < 2; d++) begin
            chk("t5_rst_no_fulfil", d, up_ful[d], 0);
            chk("t5_rst_busy", d, bsy[d], 0);
        end
        tick();
        at_neg();
        chk("t5_rst_no_fulfil_2", 1, up_ful[1], 0);
        tick();
        reset = 1'b0;
        for (int d = 0; d < 2; d++) l2(d, 1'b0, '0);
        at_neg();
        for (int d = 0; d < 2; d++) begin
            chk("t5_after_idle", d, dstate[d], 0);
            chk("t5_after_grant_p0", d, gnt[d], 4'b0001);
        end
        chk("t5_after_ptr0", 1, dptr[1], 2'd0);
        tick();
        for (int d = 0; d < 2; d++) l2(d, 1'b1, 32'h4242);
        tick();
        for (int d = 0; d < 2; d++) clear(d);
        tick();
        at_neg();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/l2_req_arbiter_rr.md
# l2_req_arbiter_rr

Parametrised N-port arbiter between the L1-side requesters (icache, dcache, and future ports such as a prefetcher or page-table walker) and the single L2 request port. It selects one requester by fixed-priority or round-robin policy and locks the grant until the L2 fulfils the request. It forwards address, type and store data to L2, and routes the fetched word and fulfilment back only to the granted port. Non-granted ports see no response.

## Interface
- XLEN, 32, address/data width
- NUM_REQ, 4, number of requester ports (1..8); port 0 is highest priority in fixed mode
- RR_MODE, 1, 1 = round-robin, 0 = fixed priority (lowest index wins)
- RO_MASK, NUM_REQ'b1, bit i set = port i is read-only; its req_type is forced to LOAD and its store data to 0
---
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- up_req_address  in  NUM_REQ*XLEN  per-port request address, port i at [i*XLEN +: XLEN]
- up_req_type  in  NUM_REQ x memory_operation_e  per-port operation (packed array)
- up_req_valid  in  NUM_REQ  per-port request valid
- up_word_to_store  in  NUM_REQ*XLEN  per-port store data
- up_fetched_word  out  NUM_REQ*XLEN  per-port returned word
- up_req_fulfilled  out  NUM_REQ  per-port fulfilment pulse
- req_address  out  XLEN  to L2
- req_type  out  memory_operation_e  to L2
- req_valid  out  1  to L2
- word_to_store  out  XLEN  to L2
- fetched_word  in  XLEN  from L2
- req_fulfilled  in  1  from L2, single-cycle pulse
- grant_onehot  out  NUM_REQ  current winner (IDLE: combinational pick; BUSY: locked grant)
- busy  out  1  state == BUSY

## Operation
- States: IDLE, BUSY. Registers: state, grant_idx (clog2 width, min 1 bit), rr_ptr.
- Winner selection, IDLE only: fixed mode picks the lowest-index valid port. RR mode picks the first valid port at or after rr_ptr, scanning upward modulo NUM_REQ.
- IDLE, any valid: the winner is muxed to L2 combinationally in the same cycle, with zero-latency issue. grant_idx <= winner.
  - If req_fulfilled is also high this cycle, the transaction completes in IDLE and state stays IDLE.
  - Otherwise state <= BUSY.
- IDLE, no valid: req_valid = 0, grant_onehot = 0, L2 outputs 0.
- BUSY: mux is fixed to grant_idx; other ports' valids are ignored.
  - req_fulfilled: state <= IDLE.
  - Granted port's valid drops before fulfilment (protocol violation): state <= IDLE, rr_ptr unchanged, and a subsequent req_fulfilled in IDLE is discarded.
- rr_ptr <= (winner + 1) mod NUM_REQ on every fulfilment. It wraps from NUM_REQ-1 to 0 and is unchanged in fixed mode.
- Response routing: the granted port gets up_fetched_word = fetched_word and up_req_fulfilled = req_fulfilled. All other ports get 0 / 0.
- req_valid = the granted port's up_req_valid.
- RO_MASK ports: req_type = LOAD, word_to_store = 0.
- NUM_REQ = 1: degenerates to a pass-through with a BUSY lock, and rr_ptr is constant 0.

## Timing
- Reset (while asserted and on the first cycle after): state = IDLE, grant_idx = 0, rr_ptr = 0.
  - During reset, req_valid = 0, grant_onehot = 0, busy = 0, and all up_req_fulfilled = 0.
- Issue latency: 0 cycles, i.e. a request is visible on the L2 port in the cycle its valid rises while IDLE.
- Completion to next issue: on a fulfil in BUSY, the next grant is chosen in the following cycle (IDLE), giving one cycle of arbitration with no dead bubble on req_valid if another port is valid.
- Reset asserted mid-transaction: state returns to IDLE next edge, the outstanding request is abandoned, and no fulfilment is forwarded while reset is high.
- Simultaneous requests in the same IDLE cycle: exactly one grant_onehot bit is set.

## Test plan
- Fixed mode (RR_MODE=0), NUM_REQ=4, ports 1 and 3 valid together, L2 fulfils after 3 cycles -> port 1 is granted first and receives fetched_word 0xDEAD_BEEF; port 3 is granted the cycle after the fulfil; port 3 never sees a fulfilment for port 1's request.
- RR mode, ports 0, 1 and 2 held valid continuously, L2 fulfils after 2 cycles -> grant order 0, 1, 2, 0; rr_ptr sequence 1, 2, 3, 1.
- RR wrap: rr_ptr = 3, ports 0 and 3 valid -> port 3 wins; after the fulfil rr_ptr = 0 and port 0 wins next.
- Zero-wait L2 (req_fulfilled in the same cycle valid rises in IDLE) -> state stays IDLE, busy stays 0, and the requester gets a 1-cycle fulfil with correct data.
- RO port 0 drives req_type = STORE with data 0x1234 -> L2 sees LOAD with word_to_store 0. Writable port 1 STORE 0x1234 -> L2 sees STORE 0x1234.
- Reset asserted in BUSY (port 2 granted) with req_fulfilled high during reset -> no up_req_fulfilled pulse; after reset, state = IDLE, rr_ptr = 0, and port 0 wins if valid.
